ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter and access sequencer for the single-port `cram` block. Two masters share one RAM: the CPU control unit (requester 0) and a DMA/debug loader (requester 1). The arbiter grants them round-robin over a level request / one-cycle acknowledge handshake. It latches the winning request, drives the RAM strobes for a configurable number of wait states, captures read data and returns it to the granted requester.

## Interface
Parameters:
- `p_data_width`, 16, width of RAM data words.
- `p_address_width`, 10, width of RAM addresses.
- `p_wait_states`, 0, extra cycles (0..15) the RAM strobe is held per access.

Ports:
- `i_w_clk`  in  1  clock; all state updates on the rising edge.
- `i_w_reset`  in  1  asynchronous, active-high reset.
- `i_w_req0` / `i_w_req1`  in  1  access request, level; held until the matching ack.
- `i_w_we0` / `i_w_we1`  in  1  1 = write, 0 = read; valid while req is high.
- `i_w_addr0` / `i_w_addr1`  in  p_address_width  access address.
- `i_w_wdata0` / `i_w_wdata1`  in  p_data_width  write data.
- `o_w_ack0` / `o_w_ack1`  out  1  one-cycle completion pulse.
- `o_w_rdata0` / `o_w_rdata1`  out  p_data_width  registered read data, per requester.
- `o_w_grant`  out  2  one-hot owner of the current access, 00 when idle.
- `o_w_ram_oe`  out  1  RAM output enable (reads).
- `o_w_ram_we`  out  1  RAM write enable (writes).
- `o_w_ram_addr`  out  p_address_width  RAM address.
- `o_w_ram_in`  out  p_data_width  data to RAM.
- `i_w_ram_out`  in  p_data_width  RAM read data; combinational while oe is high.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request pending: all RAM outputs 0, `o_w_grant` = 00.
- IDLE, exactly one req high: grant that requester.
- IDLE, both req high: grant the requester that was not served last (`last` pointer).
- Grant actions (IDLE -> ACCESS):
  - latch we, addr and wdata of the winner into internal registers;
  - set `o_w_grant`;
  - load the wait counter with `p_wait_states`.
- ACCESS:
  - `o_w_ram_addr` and `o_w_ram_in` come from the latched registers, never from live inputs.
  - `o_w_ram_we` = latched we; `o_w_ram_oe` = not latched we.
  - The counter decrements each cycle. When it reaches 0, go to DONE.
  - On that same edge, a read captures `i_w_ram_out` into the winner's rdata register.
  - Because writes hold the strobe, repeated writes of the same word during the hold are expected and harmless.
- DONE:
  - RAM strobes are 0; `o_w_grant` is still set.
  - The winner's ack is high for this one cycle.
  - `last` is set to the winner; next state is IDLE.
- `o_w_rdata*` holds its value until the next read completed for that requester. Writes do not change it.
- A requester drops req at or after the edge that ends its ack cycle. If req is still high when IDLE samples, that is a new request.
- Req dropped during ACCESS: the access completes and ack is still pulsed. Live input changes after the grant are ignored.
- Counter is 4 bits; `p_wait_states` > 15 is illegal.

## Timing
- Reset values (asynchronous): state IDLE; all acks 0; `o_w_grant` 00; `o_w_ram_oe`/`o_w_ram_we` 0; `o_w_ram_addr`, `o_w_ram_in`, `o_w_rdata0`, `o_w_rdata1` all 0.
- `last` resets to 1, so requester 0 wins the first tie.
- Reset mid-access aborts immediately: strobes drop asynchronously and no ack is issued.
- All outputs are registered or decoded from registered state only; no combinational path from req to any output.
- Req sampled high at edge E (state IDLE):
  - ACCESS runs from E to E+W+1, with W = `p_wait_states`.
  - Ack is high during the cycle after E+W+1.
  - Read data is valid at `o_w_rdata*` in that same cycle.
- Requester round trip with W = 0: req high -> ack in the second cycle after it was sampled. Occupancy is W+2 cycles per access.
- Back-to-back: if the other requester's req was already high, it is granted at the edge that ends DONE. Under continuous contention the grants alternate strictly.

## Test plan
- Reset, no requests, W=0: all outputs 0, grant 00 for 10 cycles; assert reset mid-ACCESS -> strobes 0 at once, no ack.
- Req0 write addr 0x005 data 0xBEEF, then req0 read 0x005, W=0: write strobe for 1 cycle, ack0 2 cycles after sample; read ack0 with `o_w_rdata0` = 0xBEEF, `o_w_rdata1` unchanged (0).
- Req0 and req1 asserted together and held, reads of 0x001/0x002 preloaded 0x1111/0x2222: grants alternate 0,1,0,1 starting with 0; each ack spaced 2 cycles; rdata0 = 0x1111, rdata1 = 0x2222.
- W=3, req1 write 0x3FF data 0x00FF: `o_w_ram_we` high exactly 4 cycles with addr 0x3FF; ack1 on 5th cycle after grant; changing `i_w_addr1` during ACCESS does not change `o_w_ram_addr`.
- Req1 dropped during ACCESS: ack1 still pulses once; no further grant to requester 1; a subsequent req0 is served immediately after DONE.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: both requester handshakes plus the RAM-side strobes.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface ram_arbiter_if #(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10
);
    logic                       i_w_req0;
    logic                       i_w_req1;
    logic                       i_w_we0;
    logic                       i_w_we1;
    logic [p_address_width-1:0] i_w_addr0;
    logic [p_address_width-1:0] i_w_addr1;
    logic [p_data_width-1:0]    i_w_wdata0;
    logic [p_data_width-1:0]    i_w_wdata1;
    logic                       o_w_ack0;
    logic                       o_w_ack1;
    logic [p_data_width-1:0]    o_w_rdata0;
    logic [p_data_width-1:0]    o_w_rdata1;
    logic [1:0]                 o_w_grant;
    logic                       o_w_ram_oe;
    logic                       o_w_ram_we;
    logic [p_address_width-1:0] o_w_ram_addr;
    logic [p_data_width-1:0]    o_w_ram_in;
    logic [p_data_width-1:0]    i_w_ram_out;

    modport slave (
        input  i_w_req0, i_w_req1, i_w_we0, i_w_we1,
        input  i_w_addr0, i_w_addr1, i_w_wdata0, i_w_wdata1,
        input  i_w_ram_out,
        output o_w_ack0, o_w_ack1, o_w_rdata0, o_w_rdata1, o_w_grant,
        output o_w_ram_oe, o_w_ram_we, o_w_ram_addr, o_w_ram_in
    );

    modport master (
        output i_w_req0, i_w_req1, i_w_we0, i_w_we1,
        output i_w_addr0, i_w_addr1, i_w_wdata0, i_w_wdata1,
        output i_w_ram_out,
        input  o_w_ack0, o_w_ack1, o_w_rdata0, o_w_rdata1, o_w_grant,
        input  o_w_ram_oe, o_w_ram_we, o_w_ram_addr, o_w_ram_in
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and access sequencer letting two requesters share the
// single-port cram; every output is registered or decoded from registered state.
module ram_arbiter #(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 10,
    parameter int unsigned p_wait_states   = 0
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    ram_arbiter_if.slave     bus
);

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_access = 2'd1;
    localparam logic [1:0] st_done   = 2'd2;

    localparam logic [3:0] wait_init = 4'(p_wait_states);

    logic [1:0]                 state_q, state_d;
    logic                       win_q, win_d;
    logic                       last_q, last_d;
    logic                       we_q, we_d;
    logic [p_address_width-1:0] addr_q, addr_d;
    logic [p_data_width-1:0]    wdata_q, wdata_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [1:0]                 grant_q, grant_d;
    logic [p_data_width-1:0]    rdata0_q, rdata0_d;
    logic [p_data_width-1:0]    rdata1_q, rdata1_d;

    logic take;
    logic take_idx;

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        take     = 1'b0;
        take_idx = 1'b0;

        case (state_q)
            st_idle: begin
                if (bus.i_w_req0 || bus.i_w_req1) begin
                    take     = 1'b1;
                    take_idx = (bus.i_w_req0 && bus.i_w_req1) ? ~last_q : bus.i_w_req1;
                end
            end

            st_access: begin
                if (cnt_q == 4'd0) begin
                    state_d = st_done;
                    if (!we_q) begin
                        if (win_q) rdata1_d = bus.i_w_ram_out;
                        else       rdata0_d = bus.i_w_ram_out;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            st_done: begin
                last_d  = win_q;
                state_d = st_idle;
                grant_d = '0;
                // The winner's req is still legally high during its ack, so only
                // the other requester may be chained straight into a new access.
                if (win_q ? bus.i_w_req0 : bus.i_w_req1) begin
                    take     = 1'b1;
                    take_idx = ~win_q;
                end
            end

            default: begin
                state_d = st_idle;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d = st_access;
            win_d   = take_idx;
            we_d    = take_idx ? bus.i_w_we1    : bus.i_w_we0;
            addr_d  = take_idx ? bus.i_w_addr1  : bus.i_w_addr0;
            wdata_d = take_idx ? bus.i_w_wdata1 : bus.i_w_wdata0;
            cnt_d   = wait_init;
            grant_d = take_idx ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            state_q  <= st_idle;
            win_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    logic in_access;
    logic in_done;

    assign in_access = (state_q == st_access);
    assign in_done   = (state_q == st_done);

    // Strobes and RAM address/data are gated by the state flop, so a reset
    // mid-access drops them asynchronously.
    assign bus.o_w_ram_we   = in_access & we_q;
    assign bus.o_w_ram_oe   = in_access & ~we_q;
    assign bus.o_w_ram_addr = in_access ? addr_q : '0;
    assign bus.o_w_ram_in   = (in_access && we_q) ? wdata_q : '0;

    assign bus.o_w_ack0   = in_done & ~win_q;
    assign bus.o_w_ack1   = in_done & win_q;
    assign bus.o_w_grant  = grant_q;
    assign bus.o_w_rdata0 = rdata0_q;
    assign bus.o_w_rdata1 = rdata1_q;

endmodule
